cv_ctrl_ports: RTL
==================

# cv_ctrl_ports

Parametrised ColecoVision controller-port front end. It sits between the per-player joystick words from hps_io and the cv_console controller pins, and serves `PORTS` players.

For each port it provides:
- a registered keypad priority encoder with a minimum key-hold stretch;
- joystick and fire multiplexing driven by the console's keypad/joystick select strobes;
- an emulated roller/spinner quadrature output fed by signed delta updates.

## Interface

Parameters:
- `PORTS`, default 2: number of controller ports, range 2..4.
- `HOLD_CE`, default 16'd2048: minimum key hold, counted in `ce` ticks. A value of 0 disables the hold stretch.
- `SPIN_DIV`, default 12'd512: `ce` ticks per quadrature step.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous reset, active-high.
- `ce` in 1: 10.7 MHz clock enable. It paces the hold and spinner counters only.
- `swap_i` in 1: when 1, the joystick inputs of ports 0 and 1 are exchanged. Ports 2 and up are unaffected.
- `joy_i` in `PORTS*20`: active-high joystick word per port, port p at bits [p*20+19 : p*20].
  - [0] right, [1] left, [2] down, [3] up
  - [4] fire1, [5] fire2
  - [6] `*`, [7] `#`
  - [17:8] digits 0..9
  - [18] purple, [19] blue
- `sel_kp_n_i` in `PORTS`: keypad select per port (console pin 5), active-low.
- `sel_joy_n_i` in `PORTS`: joystick select per port (console pin 8), active-low.
- `spin_i` in `PORTS*8`: signed spinner delta per port.
- `spin_stb_i` in `PORTS`: per-port strobe; the delta is accepted on a cycle where the strobe is 1.
- `ctrl_d_o` out `PORTS*4`: pins {p1,p2,p3,p4} per port, active-low.
- `ctrl_p6_o` out `PORTS`: fire pin per port, active-low.
- `ctrl_p7_o` out `PORTS`: spinner quadrature A.
- `ctrl_p9_o` out `PORTS`: spinner quadrature B.

## Operation

**Input stage**
- `joy_i` is registered after the swap is applied: `jr[p]`.

**Keypad encoder**
- Raw code is taken from `jr[p]` with priority 0,1,…,9,`*`,`#`,purple,blue.
- Codes: 0=0011, 1=1110, 2=1101, 3=0110, 4=0001, 5=1001, 6=0111, 7=1100, 8=1000, 9=1011, `*`=1010, `#`=0101, purple=0100, blue=0010, none=1111.

**Hold stretch** (per port: `held[p]` 4b, `hcnt[p]` 16b)
- Raw code ≠ none: `held <= raw`, `hcnt <= HOLD_CE`.
- Otherwise, if `hcnt` ≠ 0 and `ce`: `hcnt` decrements; `held` is unchanged.
- Otherwise, if `hcnt` = 0: `held <= 1111`.
- A key change while held replaces `held` immediately and reloads `hcnt`.

**Pin multiplexing** (registered into the outputs)
- `kp` = `sel_kp_n` low ? `held` : 1111.
- `js` = `sel_joy_n` low ? ~{up, down, left, right} : 1111.
- `ctrl_d` = `kp & js`.
- `ctrl_p6` = ~(`sel_kp` active & fire2) & ~(`sel_joy` active & fire1).
- When both selects are active, the two sources are ANDed.

**Spinner** (per port: `acc` signed 10b, `sdiv` 12b, `phase` 2b)
- On `spin_stb`: `acc <= sat(acc + sext(spin_i))`, saturating to [-511, +511].
- `sdiv` counts `ce` ticks and wraps at `SPIN_DIV-1`. At the wrap:
  - if `acc` > 0: phase steps forward 00→01→11→10→00 and `acc` decrements;
  - if `acc` < 0: phase steps reverse and `acc` increments;
  - if `acc` = 0: no step.
- Strobe and step in the same cycle: `acc <= sat(acc + delta ∓ 1)`.
- `ctrl_p7 = phase[0]`, `ctrl_p9 = phase[1]`.

## Timing

**Reset values**
- `ctrl_d_o` all 1; `ctrl_p6_o` all 1; `ctrl_p7_o` = `ctrl_p9_o` = 0.
- Internally: `held` = 1111, `hcnt` = 0, `acc` = 0, `sdiv` = 0, `phase` = 00, `jr` = 0.

**Latency**
- `joy_i`/`swap_i` → `jr`: 1 clk.
- `jr` → `held`: 1 clk.
- `held` → `ctrl_d_o`: 1 clk.
- Total key press → pin: 3 `clk_sys`.
- `sel_*` or joystick → pins: 2 clk.

**Other timing**
- `hcnt` and `sdiv` advance only on `ce`. Select strobes and the output registers update every clk, independent of `ce`.
- A spinner step is visible on p7/p9 in the cycle after the `sdiv` wrap.
- Reset asserted mid-hold or mid-rotation returns all state to the reset values on the next edge. No quadrature step is emitted from a pending `acc`.
- `swap_i` toggling takes effect after 1 clk. The hold state is per physical port and is not swapped.

## Test plan

1. **Reset.** Assert reset 2 clk with keys pressed → `ctrl_d_o` = all 1, `ctrl_p6_o` = all 1, p7/p9 = 0. Release → 3 clk later port 0 shows the key code, provided `sel_kp_n[0]` = 0.
2. **Priority and hold.** Port 0: set `joy_i[9:8]` = 2'b11 (digits 0 and 1), `sel_kp_n` = 0 → `ctrl_d[3:0]` = 0011. Tap digit 5 for 1 clk with `HOLD_CE` = 4 and `ce` every 4th clk → 1001 for 4 `ce` ticks (±1 clk), then 1111.
3. **Joystick/fire mux.** `sel_joy_n` = 0, `sel_kp_n` = 1, up+right+fire1 → `ctrl_d` = 0110, `ctrl_p6` = 0. Both selects active with key 8 plus up → `ctrl_d` = 0000.
4. **Swap.** Digit 3 on port 1 input, `swap_i` = 1 → port 0 `ctrl_d` = 0110 and port 1 = 1111. With `PORTS` = 4, ports 2–3 are unchanged.
5. **Spinner.** `spin_i` = +3 strobe, `SPIN_DIV` = 2 → phase 01, 11, 10 at successive wraps, then static with `acc` = 0. A delta of -2 steps back 11, 01.
6. **Spinner saturation and simultaneous update.** Strobe +127 five times → `acc` saturates at +511. Strobe -1 on the same cycle as a step → `acc` = 509.

Source files
------------

// File: rtl/cv_ctrl_ports.sv
// ColecoVision controller-port front end: keypad encoder with hold stretch,
// joystick/fire pin multiplexing and an emulated quadrature spinner per port.
module cv_ctrl_ports #(
  parameter int          PORTS    = 2,
  parameter logic [15:0] HOLD_CE  = 16'd2048,
  parameter logic [11:0] SPIN_DIV = 12'd512
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce,
  input  logic                swap_i,
  input  logic [PORTS*20-1:0] joy_i,
  input  logic [PORTS-1:0]    sel_kp_n_i,
  input  logic [PORTS-1:0]    sel_joy_n_i,
  input  logic [PORTS*8-1:0]  spin_i,
  input  logic [PORTS-1:0]    spin_stb_i,
  output logic [PORTS*4-1:0]  ctrl_d_o,
  output logic [PORTS-1:0]    ctrl_p6_o,
  output logic [PORTS-1:0]    ctrl_p7_o,
  output logic [PORTS-1:0]    ctrl_p9_o
);

  localparam logic [11:0] DIV_LAST = SPIN_DIV - 12'd1;

  logic [PORTS-1:0] r_sel_kp_n;
  logic [PORTS-1:0] r_sel_joy_n;

  // Selects get one register stage so they line up with the registered joystick word.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sel_kp_n  <= '1;
      r_sel_joy_n <= '1;
    end else begin
      r_sel_kp_n  <= sel_kp_n_i;
      r_sel_joy_n <= sel_joy_n_i;
    end
  end

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    localparam int SRC = (gi == 0) ? 1 : ((gi == 1) ? 0 : gi);

    logic [19:0]       w_joy;
    logic [19:0]       r_jr;
    logic [3:0]        w_raw;
    logic [3:0]        r_held;
    logic [15:0]       r_hcnt;
    logic [3:0]        w_kp;
    logic [3:0]        w_js;
    logic              w_p6;
    logic [3:0]        r_d;
    logic              r_p6;
    logic [7:0]        w_delta;
    logic              w_wrap;
    logic              w_fwd;
    logic              w_rev;
    logic signed [11:0] w_sum;
    logic signed [9:0] w_acc_next;
    logic signed [9:0] r_acc;
    logic [11:0]       r_sdiv;
    logic [1:0]        r_phase;

    assign w_joy = swap_i ? joy_i[SRC*20 +: 20] : joy_i[gi*20 +: 20];

    always_ff @(posedge clk_sys) begin
      if (reset) r_jr <= '0;
      else       r_jr <= w_joy;
    end

    always_comb begin
      w_raw = 4'b1111;
      if      (r_jr[8])  w_raw = 4'b0011;
      else if (r_jr[9])  w_raw = 4'b1110;
      else if (r_jr[10]) w_raw = 4'b1101;
      else if (r_jr[11]) w_raw = 4'b0110;
      else if (r_jr[12]) w_raw = 4'b0001;
      else if (r_jr[13]) w_raw = 4'b1001;
      else if (r_jr[14]) w_raw = 4'b0111;
      else if (r_jr[15]) w_raw = 4'b1100;
      else if (r_jr[16]) w_raw = 4'b1000;
      else if (r_jr[17]) w_raw = 4'b1011;
      else if (r_jr[6])  w_raw = 4'b1010;
      else if (r_jr[7])  w_raw = 4'b0101;
      else if (r_jr[18]) w_raw = 4'b0100;
      else if (r_jr[19]) w_raw = 4'b0010;
    end

    // Any pressed key reloads the stretch; release only clears once the count has drained.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_held <= 4'b1111;
        r_hcnt <= '0;
      end else if (w_raw != 4'b1111) begin
        r_held <= w_raw;
        r_hcnt <= HOLD_CE;
      end else if (r_hcnt != 16'd0) begin
        if (ce) r_hcnt <= r_hcnt - 16'd1;
      end else begin
        r_held <= 4'b1111;
      end
    end

    assign w_kp = r_sel_kp_n[gi]  ? 4'b1111 : r_held;
    assign w_js = r_sel_joy_n[gi] ? 4'b1111 : ~r_jr[3:0];
    assign w_p6 = ~(~r_sel_kp_n[gi] & r_jr[5]) & ~(~r_sel_joy_n[gi] & r_jr[4]);

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_d  <= 4'b1111;
        r_p6 <= 1'b1;
      end else begin
        r_d  <= w_kp & w_js;
        r_p6 <= w_p6;
      end
    end

    assign w_delta = spin_i[gi*8 +: 8];
    assign w_wrap  = ce && (r_sdiv == DIV_LAST);
    assign w_fwd   = w_wrap && !r_acc[9] && (r_acc != 10'sd0);
    assign w_rev   = w_wrap && r_acc[9];

    // Strobe and step fold into one saturating sum so neither update is lost.
    always_comb begin
      w_sum = $signed({{2{r_acc[9]}}, r_acc});
      if (spin_stb_i[gi]) w_sum = w_sum + $signed({{4{w_delta[7]}}, w_delta});
      if (w_fwd) w_sum = w_sum - 12'sd1;
      if (w_rev) w_sum = w_sum + 12'sd1;
      if (w_sum > 12'sd511)       w_acc_next = 10'sd511;
      else if (w_sum < -12'sd511) w_acc_next = -10'sd511;
      else                        w_acc_next = w_sum[9:0];
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_acc   <= '0;
        r_sdiv  <= '0;
        r_phase <= 2'b00;
      end else begin
        r_acc <= w_acc_next;
        if (ce) r_sdiv <= (r_sdiv == DIV_LAST) ? 12'd0 : r_sdiv + 12'd1;
        if (w_fwd)      r_phase <= {r_phase[0], ~r_phase[1]};
        else if (w_rev) r_phase <= {~r_phase[0], r_phase[1]};
      end
    end

    assign ctrl_d_o[gi*4 +: 4] = r_d;
    assign ctrl_p6_o[gi]       = r_p6;
    assign ctrl_p7_o[gi]       = r_phase[0];
    assign ctrl_p9_o[gi]       = r_phase[1];
  end

endmodule
